// File: rtl/seq_frame_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : seq_frame_ctrl_pkg                                   |
// | Description : Shared FSM state encoding and counter-width helper   |
// |               for the serial-frame sequencer.                      |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
package seq_frame_ctrl_pkg;

    // Sequencer states; the encoding is shared with the detector bench.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

    // Bits needed to hold a counter that runs 0..n-1 (never narrower than 1).
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_bit_tick.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : seq_bit_tick                                         |
// | Description : Bit-period divider. Emits one tick every DIV cycles  |
// |               while enabled; reloads whenever disabled so each     |
// |               frame starts with a full bit period.                 |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module seq_bit_tick
    import seq_frame_ctrl_pkg::*;
#(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int                 c_DIV_W = cnt_width(DIV);
    localparam logic [c_DIV_W-1:0] c_RELOAD = c_DIV_W'(DIV - 1);

    logic [c_DIV_W-1:0] r_cnt;

    // Tick on the last cycle of each bit period; depends on registered state only.
    assign tick = en && (r_cnt == '0);

    // Down-counter: held at reload while disabled, wraps to reload after each tick.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_cnt <= '0;
        end else if (!en || tick) begin
            r_cnt <= c_RELOAD;
        end else begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/seq_frame_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : seq_frame_ctrl                                       |
// | Description : Serial pattern-detector sequencer. Latches a word on |
// |               a start edge, shifts it out LSB-first with a valid   |
// |               strobe, counts detector matches (saturating) and     |
// |               holds the result with a done flag.                   |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module seq_frame_ctrl
    import seq_frame_ctrl_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5,
    parameter int DIV   = 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] data_in,
    input  logic             match_in,
    output logic             det_clr,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count
);

    localparam int                 c_IDX_W    = cnt_width(WIDTH);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]   c_CNT_MAX  = '1;

    seq_state_t         r_state;
    seq_state_t         w_state_nxt;
    logic [WIDTH-1:0]   r_shreg;
    logic [c_IDX_W-1:0] r_idx;
    logic [CNT_W-1:0]   r_count;
    logic               r_start_q;
    logic               w_start_edge;
    logic               w_tick_en;
    logic               w_tick;

    assign w_start_edge = start & ~r_start_q;
    assign w_tick_en    = (r_state == ST_SHIFT);
    assign count        = r_count;

    // Bit-period timing; disabled (and therefore reloaded) outside SHIFT.
    seq_bit_tick #(
        .DIV (DIV)
    ) u_bit_tick (
        .clk  (clk),
        .clr  (clr),
        .en   (w_tick_en),
        .tick (w_tick)
    );

    // State register.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and output decode from registered state.
    always_comb begin
        w_state_nxt = r_state;
        det_clr     = (r_state == ST_LOAD);
        busy        = (r_state == ST_LOAD) || (r_state == ST_SHIFT);
        done        = (r_state == ST_DONE);
        bit_valid   = (r_state == ST_SHIFT) && w_tick;
        bit_out     = (r_state == ST_SHIFT) && r_shreg[0];

        if (abort) begin
            // abort wins over everything, including a simultaneous start edge
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  if (w_start_edge) w_state_nxt = ST_LOAD;
                ST_LOAD:  w_state_nxt = ST_SHIFT;
                ST_SHIFT: if (bit_valid && (r_idx == c_IDX_LAST)) w_state_nxt = ST_DONE;
                ST_DONE:  if (w_start_edge) w_state_nxt = ST_LOAD;
                default:  w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Datapath: edge detector, shift register, bit index and match counter.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_start_q <= 1'b0;
            r_shreg   <= '0;
            r_idx     <= '0;
            r_count   <= '0;
        end else begin
            // tracks start in every state so a press held across abort cannot retrigger
            r_start_q <= start;
            if (r_state == ST_LOAD) begin
                r_shreg <= data_in;
                r_idx   <= '0;
                r_count <= '0;
            end else if (bit_valid) begin
                r_shreg <= r_shreg >> 1;
                r_idx   <= r_idx + 1'b1;
                if (match_in && (r_count != c_CNT_MAX)) begin
                    r_count <= r_count + 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_frame_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : tb_seq_frame_ctrl                                    |
// | Description : Scoreboard bench for seq_frame_ctrl. Three instances |
// |               (DIV=1/CNT_W=5, DIV=4/CNT_W=5, DIV=1/CNT_W=3) share  |
// |               stimulus; a frame-level model predicts counts.       |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module tb_seq_frame_ctrl;

    localparam int c_N     = 3;
    localparam int c_WIDTH = 16;

    function automatic int div_of(input int k);
        return (k == 1) ? 4 : 1;
    endfunction

    function automatic int cntw_of(input int k);
        return (k == 2) ? 3 : 5;
    endfunction

    logic               clk = 1'b0;
    logic               clr;
    logic               start;
    logic               abort;
    logic [c_WIDTH-1:0] data_in;
    logic [c_N-1:0]     match_in;
    logic [c_N-1:0]     det_clr;
    logic [c_N-1:0]     bit_out;
    logic [c_N-1:0]     bit_valid;
    logic [c_N-1:0]     busy;
    logic [c_N-1:0]     done;
    logic [7:0]         count [c_N];

    int n_checks = 0;
    int n_errors = 0;

    // scoreboard: frame words issued, final counts predicted
    logic [c_WIDTH-1:0] exp_data [c_N][$];
    int                 exp_cnt  [c_N][$];

    // monitor bookkeeping
    int                 cyc = 0;
    int                 t_load   [c_N];
    int                 bit_i    [c_N];
    int                 held_cnt [c_N];
    logic [c_WIDTH-1:0] cur_data [c_N];
    bit                 prev_done[c_N];

    always #5 clk = ~clk;

    for (genvar g = 0; g < c_N; g++) begin : g_dut
        logic [cntw_of(g)-1:0] w_cnt;
        seq_frame_ctrl #(
            .WIDTH (c_WIDTH),
            .CNT_W (cntw_of(g)),
            .DIV   (div_of(g))
        ) u_dut (
            .clk       (clk),
            .clr       (clr),
            .start     (start),
            .abort     (abort),
            .data_in   (data_in),
            .match_in  (match_in[g]),
            .det_clr   (det_clr[g]),
            .bit_out   (bit_out[g]),
            .bit_valid (bit_valid[g]),
            .busy      (busy[g]),
            .done      (done[g]),
            .count     (w_cnt)
        );
        assign count[g] = 8'(w_cnt);
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic int sat_inc(input int v, input int k);
        int lim;
        lim = (1 << cntw_of(k)) - 1;
        return (v + 1 > lim) ? lim : v + 1;
    endfunction

    // Monitor: samples on the falling edge and retires scoreboard entries.
    initial begin
        for (int k = 0; k < c_N; k++) begin
            t_load[k] = 0; bit_i[k] = 0; held_cnt[k] = -1; cur_data[k] = '0; prev_done[k] = 1'b0;
        end
        forever begin
            @(negedge clk);
            cyc++;
            if (!clr) begin
                for (int k = 0; k < c_N; k++) begin
                    if (det_clr[k]) begin
                        check($sformatf("det_clr expected[%0d]", k), int'(exp_data[k].size() > 0), 1);
                        check($sformatf("busy in LOAD[%0d]", k), int'(busy[k]), 1);
                        check($sformatf("done in LOAD[%0d]", k), int'(done[k]), 0);
                        if (exp_data[k].size() > 0) cur_data[k] = exp_data[k].pop_front();
                        t_load[k] = cyc;
                        bit_i[k]  = 0;
                    end else if (busy[k]) begin
                        if (bit_i[k] < c_WIDTH)
                            check($sformatf("bit_out[%0d] bit %0d", k, bit_i[k]), int'(bit_out[k]),
                                  int'(cur_data[k][bit_i[k]]));
                        if (bit_valid[k]) begin
                            check($sformatf("bit_valid timing[%0d]", k), cyc - t_load[k],
                                  div_of(k) * (bit_i[k] + 1));
                            bit_i[k]++;
                        end
                    end
                    if (bit_valid[k])
                        check($sformatf("bit_valid while not busy[%0d]", k), int'(busy[k]), 1);
                    if (done[k] && !prev_done[k]) begin
                        check($sformatf("done expected[%0d]", k), int'(exp_cnt[k].size() > 0), 1);
                        check($sformatf("done timing[%0d]", k), cyc - t_load[k], c_WIDTH * div_of(k) + 1);
                        held_cnt[k] = (exp_cnt[k].size() > 0) ? exp_cnt[k].pop_front() : -1;
                        check($sformatf("count at done[%0d]", k), int'(count[k]), held_cnt[k]);
                    end else if (done[k]) begin
                        check($sformatf("count held[%0d]", k), int'(count[k]), held_cnt[k]);
                    end
                    prev_done[k] = done[k];
                end
            end
        end
    end

    // One frame of stimulus. mode: 0 no matches, 1 all matches, 2 loop back
    // the serial bit, 3 random. abort_t / clr_t: cycle after LOAD (-1 = none).
    task automatic run_frame(input logic [c_WIDTH-1:0] d, input int mode, input bit hold,
                             input bit noise, input int abort_t, input int clr_t);
        int mcnt  [c_N];
        bit alive [c_N];
        bit ab;
        bit m;
        int idx;
        start    = 1'b0;
        abort    = 1'b0;
        match_in = '0;
        @(posedge clk); #1;
        for (int k = 0; k < c_N; k++) begin
            exp_data[k].push_back(d);
            mcnt[k]  = 0;
            alive[k] = 1'b1;
        end
        start   = 1'b1;
        data_in = d;
        @(posedge clk); #1;
        for (int t = 0; t < 68; t++) begin
            if (t > 0) data_in = 16'($urandom);
            if (!hold) start = (noise && t >= 3 && t <= 14) ? 1'($urandom) : 1'b0;
            ab    = (t == abort_t);
            abort = ab;
            if (ab) start = 1'b1;
            for (int k = 0; k < c_N; k++) begin
                idx = (t > 0) ? (t - 1) / div_of(k) : 0;
                case (mode)
                    0:       m = 1'b0;
                    1:       m = 1'b1;
                    2:       m = (t > 0 && idx < c_WIDTH) ? d[idx] : 1'b0;
                    default: m = 1'($urandom);
                endcase
                if (ab) m = 1'b0;
                match_in[k] = m;
                // bit i is presented (valid) in cycle DIV*(i+1) after LOAD
                if (alive[k] && t > 0 && (t % div_of(k)) == 0) begin
                    if (m) mcnt[k] = sat_inc(mcnt[k], k);
                    if (t / div_of(k) == c_WIDTH) begin
                        exp_cnt[k].push_back(mcnt[k]);
                        alive[k] = 1'b0;
                    end
                end
                if (ab) alive[k] = 1'b0;
            end
            if (t == clr_t) begin
                #1 clr = 1'b1;
                #1;
                check("clr flags zero", int'({det_clr, bit_out, bit_valid, busy, done}), 0);
                check("clr counts zero", int'(count[0] | count[1] | count[2]), 0);
                for (int k = 0; k < c_N; k++) begin
                    exp_data[k].delete();
                    exp_cnt[k].delete();
                    alive[k] = 1'b0;
                end
                #1 clr = 1'b0;
            end
            @(posedge clk); #1;
        end
        abort    = 1'b0;
        match_in = '0;
        if (abort_t >= 0) begin
            for (int k = 0; k < c_N; k++) begin
                check($sformatf("abort count[%0d]", k), int'(count[k]), mcnt[k]);
                check($sformatf("abort busy[%0d]", k), int'(busy[k]), 0);
                check($sformatf("abort done[%0d]", k), int'(done[k]), 0);
            end
        end
        if (hold) begin
            repeat (4) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        clr      = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        data_in  = '0;
        match_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset flags", int'({det_clr, bit_out, bit_valid, busy, done}), 0);
        check("reset counts", int'(count[0] | count[1] | count[2]), 0);
        clr = 1'b0;

        run_frame(16'h0000, 0, 1'b0, 1'b0, -1, -1);
        run_frame(16'hA5A5, 2, 1'b0, 1'b0, -1, -1);
        run_frame(16'h3C5A, 1, 1'b0, 1'b0, -1, -1);
        run_frame(16'hFFFF, 0, 1'b0, 1'b0, -1, -1);
        repeat (6) run_frame(16'($urandom), 3, 1'b0, 1'b1, -1, -1);
        run_frame(16'($urandom), 3, 1'b0, 1'b0, 5, -1);
        run_frame(16'($urandom), 3, 1'b1, 1'b0, -1, -1);
        run_frame(16'($urandom), 1, 1'b0, 1'b0, -1, 8);
        run_frame(16'($urandom), 3, 1'b0, 1'b1, -1, -1);
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < c_N; k++) begin
            check($sformatf("frames left[%0d]", k), exp_data[k].size(), 0);
            check($sformatf("counts left[%0d]", k), exp_cnt[k].size(), 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no end of run expected finish by 200000");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
